// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity constants and parity helper
// Contents:
//   ST_IDLE..ST_STOP    state encoding values, uart_state_t enum built on them
//   PAR_MODE_EVEN/ODD   parity-mode selector values
//   MAX_DATA_BITS       widest supported data word
//   uart_parity()       parity bit of a zero-extended word (even, or odd when odd=1)
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

  localparam logic PAR_MODE_EVEN = 1'b0;
  localparam logic PAR_MODE_ODD  = 1'b1;

  localparam int MAX_DATA_BITS = 9;

  // Unused upper bits of word must be zero so they do not disturb the XOR.
  function automatic logic uart_parity(input logic [MAX_DATA_BITS-1:0] word,
                                       input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing one bit_tick per serial bit
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous reset, active-low
//   restart   in   synchronous restart: counter forced to 0 while high
//   bit_tick  out  high during the last clock of each bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_tick = (cnt_q == CNT_LAST);

  // Wrap happens only through bit_tick, so non-power-of-two periods are exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart || bit_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmitter with one-entry holding register
// Ports:
//   clk        in   clock
//   reset_n    in   asynchronous reset, active-low
//   tx_valid   in   tx_data is valid
//   tx_ready   out  holding register empty; word taken on tx_valid & tx_ready
//   tx_data    in   word to send, sampled on the handshake edge only
//   tx_serial  out  serial line, idles high (registered)
//   tx_busy    out  a frame is on the line
//   tx_done    out  one-clock pulse during the final clock of the last stop bit
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS ||
      PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_error
    $error("uart_tx_framer: illegal parameter value");
  end

  localparam int BI_W = $clog2(DATA_BITS);
  localparam logic [BI_W-1:0] BIT_LAST  = BI_W'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            ODD_MODE  = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full_q;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 serial_q, serial_d;
  logic                 bit_tick;
  logic                 load;
  logic                 accept;
  logic [MAX_DATA_BITS-1:0] hold_ext;

  assign tx_ready  = !hold_full_q;
  assign tx_busy   = (state_q != IDLE);
  assign tx_serial = serial_q;
  // hold_full_q is low whenever accept is possible and high whenever load is,
  // so the two never coincide.
  assign accept    = tx_valid && !hold_full_q;

  always_comb begin
    hold_ext = '0;
    hold_ext[DATA_BITS-1:0] = hold_q;
  end

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart  (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  // serial_d is the line level for the state being entered, so the pin
  // changes on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    serial_d   = serial_q;
    load       = 1'b0;
    tx_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q != BIT_LAST) begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end else if (PARITY_EN != 0) begin
            state_d  = PARITY;
            serial_d = parity_q;
          end else begin
            state_d    = STOP;
            stop_idx_d = 1'b0;
            serial_d   = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          serial_d   = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_idx_q != STOP_LAST) begin
            stop_idx_d = stop_idx_q + 1'b1;
          end else begin
            tx_done = 1'b1;
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d  = IDLE;
              serial_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
    // Reload from IDLE or straight out of the last stop bit.
    if (load) begin
      state_d  = START;
      shift_d  = hold_q;
      serial_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      serial_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      serial_q   <= serial_d;
      if (load) parity_q <= uart_parity(hold_ext, ODD_MODE);
      if (accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed frame checks for uart_tx_framer at CLKS_PER_BIT=4
module tb_uart_tx_framer;

  localparam int C = 4;

  logic       clk;
  logic       reset_n;
  logic [4:0] vld;
  logic [8:0] bus;
  logic [4:0] ser, rdy, busy, done;

  int errors = 0;
  int checks = 0;

  // inst0 8N1, inst1 8E1, inst2 8O1, inst3 8N2, inst4 5N1
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx_data(bus[7:0]),
    .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx_data(bus[7:0]),
    .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx_data(bus[7:0]),
    .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .reset_n(reset_n), .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx_data(bus[7:0]),
    .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));
  uart_tx_framer #(.CLKS_PER_BIT(C), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u4 (
    .clk(clk), .reset_n(reset_n), .tx_valid(vld[4]), .tx_ready(rdy[4]), .tx_data(bus[4:0]),
    .tx_serial(ser[4]), .tx_busy(busy[4]), .tx_done(done[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         inst;
    string      name;
    logic [8:0] data;
    string      exp;   // transmitted bit levels in line order, start bit first
  } vec_t;

  vec_t vecs[7];

  // Packed as {serial, done, busy, ready}.
  task automatic check(input string nm, input int cyc, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got{ser,done,busy,rdy}=%b want=%b", nm, cyc, got, want);
    end
  endtask

  task automatic run_frame(input int k, input string nm, input logic [8:0] d, input string exp,
                           input int fbits, input int inj, input logic [8:0] d2);
    int total;
    int fclks;
    logic eser, edone, erdy;
    total = exp.len() * C;
    fclks = fbits * C;
    @(negedge clk);
    check({nm, "_idle"}, -2, {ser[k], done[k], busy[k], rdy[k]}, 4'b1001);
    bus = d;
    vld[k] = 1'b1;
    @(negedge clk);
    vld[k] = 1'b0;
    bus = 9'h000;
    check({nm, "_accepted"}, -1, {ser[k], done[k], busy[k], rdy[k]}, 4'b1000);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      eser  = (exp[c / C] == 8'h31);
      edone = ((c + 1) % fclks == 0);
      erdy  = (inj < 0) ? 1'b1 : !(c > inj && c < fclks);
      check(nm, c, {ser[k], done[k], busy[k], rdy[k]}, {eser, edone, 1'b1, erdy});
      if (c == inj) begin
        bus = d2;
        vld[k] = 1'b1;
      end
      if (c == inj + 1) bus = 9'h0F0;
      if (c == inj + 3) vld[k] = 1'b0;
    end
    @(negedge clk);
    check({nm, "_after"}, total, {ser[k], done[k], busy[k], rdy[k]}, 4'b1001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, "a5_8n1",   9'h0A5, "0101001011"};
    vecs[1] = '{1, "07_8e1",   9'h007, "01110000011"};
    vecs[2] = '{2, "07_8o1",   9'h007, "01110000001"};
    vecs[3] = '{3, "00_8n2",   9'h000, "00000000011"};
    vecs[4] = '{4, "1f_5n1",   9'h1FF, "0111111"};
    vecs[5] = '{1, "fe_8e1",   9'h0FE, "00111111111"};
    vecs[6] = '{2, "fe_8o1",   9'h0FE, "00111111101"};

    reset_n = 1'b0;
    vld = '0;
    bus = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++)
      check("reset_state", k, {ser[k], done[k], busy[k], rdy[k]}, 4'b1001);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++)
      check("post_reset", k, {ser[k], done[k], busy[k], rdy[k]}, 4'b1001);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].inst, vecs[i].name, vecs[i].data, vecs[i].exp, vecs[i].exp.len(), -1, 9'h000);

    // Second word taken during DATA of the first, reloaded with no idle gap.
    run_frame(0, "b2b_55_aa", 9'h055, "01010101010010101011", 10, 6, 9'h0AA);

    // Reset during data bit 3 of 0xFF, then a clean frame.
    @(negedge clk);
    bus = 9'h0FF;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check("ff_before_reset", c, {ser[0], done[0], busy[0], rdy[0]}, {(c >= 4), 1'b0, 1'b1, 1'b1});
    end
    reset_n = 1'b0;
    #1;
    check("reset_immediate", 0, {ser[0], done[0], busy[0], rdy[0]}, 4'b1001);
    repeat (2) @(negedge clk);
    check("reset_held", 0, {ser[0], done[0], busy[0], rdy[0]}, 4'b1001);
    reset_n = 1'b1;
    run_frame(0, "3c_after_reset", 9'h03C, "0001111001", 10, -1, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
